// File: rtl/packet_route_scheduler.sv
// Round-robin scheduler moving complete packets from input buffers
// to the output buffer named by each packet's dest field.
//
// Ports:
//   clock, reset_n   rising-edge clock, synchronous active-low reset
//   in_loaded        per-input "holds a full packet" flags
//   in_data          per-input 32-bit packets, input i at [32*i +: 32]
//   out_free         per-output "can accept one packet" flags
//   data_routed      one-cycle release pulse back to the winning input
//   out_valid        one-cycle write strobe to the destination output
//   out_data         packet being written, shared by all outputs
//   drop_pulse       one-cycle pulse when a packet's dest is out of range
//   busy             high during the transfer cycle
module packet_route_scheduler #(
  parameter int NUM_PORTS = 4,
  parameter int DEST_LSB  = 24
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_PORTS-1:0]   in_loaded,
  input  logic [NUM_PORTS*32-1:0] in_data,
  input  logic [NUM_PORTS-1:0]   out_free,
  output logic [NUM_PORTS-1:0]   data_routed,
  output logic [NUM_PORTS-1:0]   out_valid,
  output logic [31:0]            out_data,
  output logic                   drop_pulse,
  output logic                   busy
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam logic [4:0] NP = 5'(NUM_PORTS);

  typedef enum logic {
    S_IDLE,
    S_XFER
  } state_t;

  state_t            r_state;
  logic [PW-1:0]     r_rr_ptr;

  logic [3:0]           w_dest [NUM_PORTS];
  logic [NUM_PORTS-1:0] w_elig;
  logic                 w_found;
  logic [PW-1:0]        w_win;
  logic [PW-1:0]        w_idx;
  logic [31:0]          w_win_data;
  logic [3:0]           w_win_dest;
  logic                 w_win_drop;
  logic [NUM_PORTS-1:0] w_win_oh;
  logic [NUM_PORTS-1:0] w_dest_oh;

  // A packet with an out-of-range dest is always eligible:
  // it only needs to be dropped, which never blocks.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_dest[i] = in_data[i*32+DEST_LSB +: 4];
      w_elig[i] = in_loaded[i] &
                  (({1'b0, w_dest[i]} >= NP) |
                   out_free[w_dest[i][PW-1:0]]);
    end
  end

  // Search starts one past the last winner; k = NUM_PORTS
  // wraps back onto the last winner itself, lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_idx = r_rr_ptr + PW'(k);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_win_data = '0;
    w_win_dest = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (PW'(i) == w_win) begin
        w_win_data = in_data[i*32 +: 32];
        w_win_dest = w_dest[i];
      end
    end
    w_win_drop = ({1'b0, w_win_dest} >= NP);
    w_win_oh   = NUM_PORTS'(1) << w_win;
    w_dest_oh  = w_win_drop ? '0 :
                 NUM_PORTS'(1) << w_win_dest[PW-1:0];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= PW'(NUM_PORTS - 1);
      data_routed <= '0;
      out_valid   <= '0;
      out_data    <= '0;
      drop_pulse  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state     <= S_XFER;
            r_rr_ptr    <= w_win;
            data_routed <= w_win_oh;
            out_valid   <= w_dest_oh;
            out_data    <= w_win_data;
            drop_pulse  <= w_win_drop;
            busy        <= 1'b1;
          end
        end
        S_XFER: begin
          // out_data deliberately keeps the last packet
          r_state     <= S_IDLE;
          data_routed <= '0;
          out_valid   <= '0;
          drop_pulse  <= 1'b0;
          busy        <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (reset_n) begin
      assert ($onehot0(data_routed))
        else $error("data_routed not one-hot");
      assert ($onehot0(out_valid))
        else $error("out_valid not one-hot");
      assert (!(drop_pulse && |out_valid))
        else $error("drop with write strobe");
    end
  end
`endif

endmodule

// File: tb/tb_packet_route_scheduler.sv
// Bench for packet_route_scheduler: vector table plus
// hand-written multi-cycle sequences, checked via a queue.
module tb_packet_route_scheduler;

  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   in_loaded;
  logic [N*32-1:0] in_data;
  logic [N-1:0]   out_free;
  logic [N-1:0]   data_routed;
  logic [N-1:0]   out_valid;
  logic [31:0]    out_data;
  logic           drop_pulse;
  logic           busy;

  always #5 clock = ~clock;

  packet_route_scheduler #(
    .NUM_PORTS(N),
    .DEST_LSB (24)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_loaded  (in_loaded),
    .in_data    (in_data),
    .out_free   (out_free),
    .data_routed(data_routed),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .drop_pulse (drop_pulse),
    .busy       (busy)
  );

  typedef struct {
    logic [3:0]  ld;
    logic [31:0] d0, d1, d2, d3;
    logic [3:0]  fr;
    logic [3:0]  e_rt;
    logic [3:0]  e_ov;
    logic [31:0] e_dat;
    logic        e_drop;
    logic        e_busy;
  } vec_t;

  typedef struct {
    logic [3:0]  rt;
    logic [3:0]  ov;
    logic [31:0] dat;
    logic        drop;
    logic        bsy;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[9];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic expect_out(input logic [3:0] rt,
                            input logic [3:0] ov,
                            input logic [31:0] dat,
                            input logic drop,
                            input logic bsy);
    exp_t e;
    e.rt = rt; e.ov = ov; e.dat = dat;
    e.drop = drop; e.bsy = bsy;
    sbq.push_back(e);
  endtask

  task automatic check_sb(input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s actual=empty required=entry", nm);
    end else begin
      e = sbq.pop_front();
      cmp({nm, ".routed"}, 32'(data_routed), 32'(e.rt));
      cmp({nm, ".valid"},  32'(out_valid),   32'(e.ov));
      cmp({nm, ".data"},   out_data,         e.dat);
      cmp({nm, ".drop"},   32'(drop_pulse),  32'(e.drop));
      cmp({nm, ".busy"},   32'(busy),        32'(e.bsy));
    end
  endtask

  task automatic drive(input logic [3:0] ld,
                       input logic [31:0] d0, d1, d2, d3,
                       input logic [3:0] fr);
    @(negedge clock);
    in_loaded = ld;
    in_data   = {d3, d2, d1, d0};
    out_free  = fr;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // rr pointer starts at 3, so input 0 leads the first search
    vt[0] = '{4'b0001, 32'h02ABCDE0, 32'h0, 32'h0, 32'h0,
              4'hF, 4'b0001, 4'b0100, 32'h02ABCDE0, 1'b0, 1'b1};
    vt[1] = '{4'b1111, 32'h010000A0, 32'h010000A1,
              32'h010000A2, 32'h010000A3,
              4'hF, 4'b0010, 4'b0010, 32'h010000A1, 1'b0, 1'b1};
    vt[2] = '{4'b1111, 32'h010000A0, 32'h010000A1,
              32'h010000A2, 32'h010000A3,
              4'hF, 4'b0100, 4'b0010, 32'h010000A2, 1'b0, 1'b1};
    vt[3] = '{4'b1111, 32'h010000A0, 32'h010000A1,
              32'h010000A2, 32'h010000A3,
              4'hF, 4'b1000, 4'b0010, 32'h010000A3, 1'b0, 1'b1};
    vt[4] = '{4'b1111, 32'h010000A0, 32'h010000A1,
              32'h010000A2, 32'h010000A3,
              4'hF, 4'b0001, 4'b0010, 32'h010000A0, 1'b0, 1'b1};
    vt[5] = '{4'b0100, 32'h0, 32'h0, 32'h09DEAD00, 32'h0,
              4'hF, 4'b0100, 4'b0000, 32'h09DEAD00, 1'b1, 1'b1};
    vt[6] = '{4'b1001, 32'h01111111, 32'h0, 32'h0, 32'h03333333,
              4'b0111, 4'b0001, 4'b0010, 32'h01111111, 1'b0, 1'b1};
    vt[7] = '{4'b0010, 32'h0, 32'h00222222, 32'h0, 32'h0,
              4'b1110, 4'b0000, 4'b0000, 32'h01111111, 1'b0, 1'b0};
    vt[8] = '{4'b0110, 32'h0, 32'h00222222, 32'h02444444, 32'h0,
              4'hF, 4'b0010, 4'b0001, 32'h00222222, 1'b0, 1'b1};

    reset_n   = 1'b0;
    in_loaded = '0;
    in_data   = '0;
    out_free  = '0;
    repeat (3) @(posedge clock);
    #1;
    expect_out(4'b0, 4'b0, 32'h0, 1'b0, 1'b0);
    check_sb("reset");
    @(negedge clock);
    reset_n = 1'b1;

    for (int v = 0; v < 9; v++) begin
      drive(vt[v].ld, vt[v].d0, vt[v].d1, vt[v].d2,
            vt[v].d3, vt[v].fr);
      expect_out(vt[v].e_rt, vt[v].e_ov, vt[v].e_dat,
                 vt[v].e_drop, vt[v].e_busy);
      tick();
      check_sb($sformatf("vec%0d", v));
      expect_out(4'b0, 4'b0, vt[v].e_dat, 1'b0, 1'b0);
      tick();
      check_sb($sformatf("vec%0d_after", v));
    end

    // Blocked input 0 is skipped, then served once out_free[3] rises
    drive(4'b0011, 32'h03555555, 32'h02666666, 32'h0, 32'h0,
          4'b0111);
    expect_out(4'b0010, 4'b0100, 32'h02666666, 1'b0, 1'b1);
    tick();
    check_sb("blk_first");
    expect_out(4'b0, 4'b0, 32'h02666666, 1'b0, 1'b0);
    tick();
    check_sb("blk_xfer_end");
    drive(4'b0001, 32'h03555555, 32'h0, 32'h0, 32'h0, 4'b0111);
    for (int c = 0; c < 3; c++) begin
      expect_out(4'b0, 4'b0, 32'h02666666, 1'b0, 1'b0);
      tick();
      check_sb($sformatf("blk_wait%0d", c));
    end
    drive(4'b0001, 32'h03555555, 32'h0, 32'h0, 32'h0, 4'hF);
    expect_out(4'b0001, 4'b1000, 32'h03555555, 1'b0, 1'b1);
    tick();
    check_sb("blk_release");
    expect_out(4'b0, 4'b0, 32'h03555555, 1'b0, 1'b0);
    tick();
    check_sb("blk_release_end");

    // Reset during XFER; pointer must return to favour input 0
    drive(4'b0010, 32'h0, 32'h01777777, 32'h0, 32'h0, 4'hF);
    expect_out(4'b0010, 4'b0010, 32'h01777777, 1'b0, 1'b1);
    tick();
    check_sb("rst_grant");
    @(negedge clock);
    reset_n = 1'b0;
    expect_out(4'b0, 4'b0, 32'h0, 1'b0, 1'b0);
    tick();
    check_sb("rst_in_xfer");
    drive(4'b0101, 32'h00888888, 32'h0, 32'h03999999, 32'h0,
          4'hF);
    reset_n = 1'b1;
    expect_out(4'b0001, 4'b0001, 32'h00888888, 1'b0, 1'b1);
    tick();
    check_sb("rst_first_grant");
    expect_out(4'b0, 4'b0, 32'h00888888, 1'b0, 1'b0);
    tick();
    check_sb("rst_first_end");

    // Idle hold, then confirm the pointer did not move
    drive(4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 4'hF);
    for (int c = 0; c < 20; c++) begin
      expect_out(4'b0, 4'b0, 32'h00888888, 1'b0, 1'b0);
      tick();
      check_sb($sformatf("idle%0d", c));
    end
    drive(4'b0011, 32'h02AAAAAA, 32'h03BBBBBB, 32'h0, 32'h0,
          4'hF);
    expect_out(4'b0010, 4'b1000, 32'h03BBBBBB, 1'b0, 1'b1);
    tick();
    check_sb("idle_ptr");
    expect_out(4'b0, 4'b0, 32'h03BBBBBB, 1'b0, 1'b0);
    tick();
    check_sb("idle_ptr_end");

    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain actual=%0d required=0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
